clip_controller: RTL

CLIP_CONTROLLER -- requirements
Module: clip_controller

---
 rtl/clip_controller.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/clip_controller.sv
// Clip record/playback sequencer: steps a per-clip sample address on each audio
// tick, drives the memory write strobe and the (de)serialiser enables.
module clip_controller #(
    parameter int NUM_CLIPS = 4,
    parameter int CLIP_LEN  = 16000,
    parameter int ADDR_W    = 16,
    localparam int SEL_W    = $clog2(NUM_CLIPS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_record,
    input  logic                 i_play,
    input  logic                 i_stop,
    input  logic                 i_loop,
    input  logic [SEL_W-1:0]     i_clip_sel,
    input  logic                 i_sample_tick,
    output logic                 o_mem_we,
    output logic [SEL_W-1:0]     o_mem_clip,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic                 o_deseriena,
    output logic                 o_seriena,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [NUM_CLIPS-1:0] o_clip_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(CLIP_LEN - 1);
    localparam logic [SEL_W:0]    NUM_CLIPS_W = (SEL_W + 1)'(NUM_CLIPS);

    state_t                r_state;
    state_t                w_next_state;
    logic [SEL_W-1:0]      r_mem_clip;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [NUM_CLIPS-1:0]  r_clip_valid;
    logic                  r_done;
    logic                  r_error;

    logic                  w_sel_ok;
    logic                  w_sel_valid;
    logic [NUM_CLIPS-1:0]  w_sel_onehot;
    logic [NUM_CLIPS-1:0]  w_clip_onehot;
    logic                  w_start;
    logic                  w_start_rec;
    logic                  w_reject;
    logic                  w_finish;
    logic                  w_rec_done;
    logic                  w_to_zero;
    logic                  w_adv;
    logic                  w_at_last;

    // One-hot decodes of the requested and latched clip; avoids out-of-range indexing
    always_comb begin
        w_sel_onehot  = '0;
        w_clip_onehot = '0;
        for (int i = 0; i < NUM_CLIPS; i++) begin
            if (i_clip_sel == SEL_W'(i)) begin
                w_sel_onehot[i] = 1'b1;
            end else begin
                w_sel_onehot[i] = 1'b0;
            end
            if (r_mem_clip == SEL_W'(i)) begin
                w_clip_onehot[i] = 1'b1;
            end else begin
                w_clip_onehot[i] = 1'b0;
            end
        end
    end

    assign w_sel_ok    = ({1'b0, i_clip_sel} < NUM_CLIPS_W);
    assign w_sel_valid = |(w_sel_onehot & r_clip_valid);
    assign w_at_last   = (r_mem_addr == LAST_ADDR);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode; stop always wins over a same-cycle tick
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_start_rec  = 1'b0;
        w_reject     = 1'b0;
        w_finish     = 1'b0;
        w_rec_done   = 1'b0;
        w_to_zero    = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_stop) begin
                    w_next_state = S_IDLE;
                end else if (i_record) begin
                    if (w_sel_ok) begin
                        w_next_state = S_REC;
                        w_start      = 1'b1;
                        w_start_rec  = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end else if (i_play) begin
                    if (w_sel_ok && w_sel_valid) begin
                        w_next_state = S_PLAY;
                        w_start      = 1'b1;
                    end else begin
                        w_reject = 1'b1;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_REC: begin
                if (i_stop) begin
                    w_next_state = S_IDLE;
                    w_to_zero    = 1'b1;
                end else if (i_sample_tick && w_at_last) begin
                    w_next_state = S_IDLE;
                    w_finish     = 1'b1;
                    w_rec_done   = 1'b1;
                    w_to_zero    = 1'b1;
                end else if (i_sample_tick) begin
                    w_adv = 1'b1;
                end else begin
                    w_next_state = S_REC;
                end
            end
            S_PLAY: begin
                if (i_stop) begin
                    w_next_state = S_IDLE;
                    w_to_zero    = 1'b1;
                end else if (i_sample_tick && w_at_last) begin
                    w_to_zero = 1'b1;
                    if (i_loop) begin
                        w_next_state = S_PLAY;
                    end else begin
                        w_next_state = S_IDLE;
                        w_finish     = 1'b1;
                    end
                end else if (i_sample_tick) begin
                    w_adv = 1'b1;
                end else begin
                    w_next_state = S_PLAY;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Address, clip latch, valid map and status pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_clip   <= '0;
            r_mem_addr   <= '0;
            r_clip_valid <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done  <= w_finish;
            r_error <= w_reject;
            if (w_start) begin
                r_mem_clip <= i_clip_sel;
                r_mem_addr <= '0;
            end else if (w_to_zero) begin
                r_mem_addr <= '0;
            end else if (w_adv) begin
                r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end else begin
                r_mem_addr <= r_mem_addr;
            end
            if (w_start_rec) begin
                r_clip_valid <= r_clip_valid & ~w_sel_onehot;
            end else if (w_rec_done) begin
                r_clip_valid <= r_clip_valid | w_clip_onehot;
            end else begin
                r_clip_valid <= r_clip_valid;
            end
        end
    end

    // State-decoded outputs; the write strobe is suppressed when stop aborts the sample
    always_comb begin
        o_mem_we    = (r_state == S_REC) && i_sample_tick && !i_stop;
        o_deseriena = (r_state == S_REC);
        o_seriena   = (r_state == S_PLAY);
        o_busy      = (r_state != S_IDLE);
    end

    assign o_mem_clip   = r_mem_clip;
    assign o_mem_addr   = r_mem_addr;
    assign o_clip_valid = r_clip_valid;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule
